// File: rtl/neuron_mac_sequencer_pkg.sv
// Shared types and helpers for the neuron MAC sequencer: state encoding,
// default widths and the ReLU-with-saturation output function.
package neuron_mac_sequencer_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int ADDR_W_DEF = 8;
   localparam int ACC_W_DEF  = 20;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_BIAS = 2'd2,
      ST_OUT  = 2'd3
   } state_t;

   // Clamp a sign-extended accumulator to [0, 2^(data_w-1)-1].
   function automatic logic [63:0] relu_sat(input logic signed [63:0] acc, input int data_w);
      logic signed [63:0] max_pos;
      max_pos = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      if (acc < 64'sd0)
         return '0;
      else if (acc > max_pos)
         return max_pos;
      else
         return acc;
   endfunction

endpackage

// File: rtl/neuron_mac_sequencer_acc.sv
// Signed multiply-accumulate register with synchronous clear and enable.
// acc_sum is the combinational next value, so the caller can use it the same cycle.
module neuron_mac_acc
#(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 20
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic              en,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [ACC_W-1:0]  acc_sum
);

   logic signed [2*DATA_W-1:0] prod;
   logic        [ACC_W-1:0]    acc;

   assign prod    = $signed(a) * $signed(b);
   assign acc_sum = acc + ACC_W'(prod);

   always_ff @(posedge clk) begin
      if (!rst_n)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc_sum;
   end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// Evaluates one neuron: streams activations against ROM weights, adds the bias
// word stored after the weights, and presents a ReLU-saturated result.
//
// state   | meaning
// IDLE    | waiting for start; ROM disabled
// MAC     | one activation/weight product per input handshake
// BIAS    | single cycle adding the bias word at base+N_INPUTS
// OUT     | result_valid held until result_ready
module neuron_mac_sequencer
   import neuron_mac_sequencer_pkg::*;
#(
   parameter int N_INPUTS = 4,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ACC_W    = ACC_W_DEF
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   output logic              busy,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   input  logic [DATA_W-1:0] rom_data,
   output logic [DATA_W-1:0] result,
   output logic              result_valid,
   input  logic              result_ready,
   output logic              done
);

   // idx must be able to hold N_INPUTS so base+idx reaches the bias word.
   localparam int IDX_W = $clog2(N_INPUTS + 1);

   state_t             state;
   logic [IDX_W-1:0]   idx;
   logic [IDX_W-1:0]   idx_nxt;
   logic [ADDR_W-1:0]  base_q;
   logic [ACC_W-1:0]   acc_sum;
   logic signed [63:0] acc_wide;
   logic [DATA_W-1:0]  mul_b;
   logic               hs;
   logic               last;
   logic               acc_clr;
   logic               acc_en;

   assign hs       = (state == ST_MAC) && in_valid && in_ready;
   assign idx_nxt  = idx + IDX_W'(1);
   assign last     = (idx == IDX_W'(N_INPUTS - 1));
   assign acc_clr  = (state == ST_IDLE) && start;
   assign acc_en   = hs || (state == ST_BIAS);
   // In BIAS the bias word is multiplied by one so the same adder path is reused.
   assign mul_b    = (state == ST_BIAS) ? DATA_W'(1) : in_data;
   assign acc_wide = 64'($signed(acc_sum));

   neuron_mac_acc #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_acc (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (acc_clr),
      .en      (acc_en),
      .a       (rom_data),
      .b       (mul_b),
      .acc_sum (acc_sum)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         idx          <= '0;
         base_q       <= '0;
         rom_addr     <= '0;
         rom_en       <= 1'b0;
         in_ready     <= 1'b0;
         busy         <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  base_q   <= base_addr;
                  idx      <= '0;
                  rom_addr <= base_addr;
                  rom_en   <= 1'b1;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  state    <= ST_MAC;
               end
            end
            ST_MAC: begin
               if (hs) begin
                  idx      <= idx_nxt;
                  rom_addr <= base_q + ADDR_W'(idx_nxt);
                  if (last) begin
                     in_ready <= 1'b0;
                     state    <= ST_BIAS;
                  end
               end
            end
            ST_BIAS: begin
               rom_en       <= 1'b0;
               result       <= DATA_W'(relu_sat(acc_wide, DATA_W));
               result_valid <= 1'b1;
               state        <= ST_OUT;
            end
            ST_OUT: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  done         <= 1'b1;
                  busy         <= 1'b0;
                  state        <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// Directed bench for neuron_mac_sequencer with N_INPUTS=3 and a behavioural ROM.
module tb_neuron_mac_sequencer;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] base_addr;
   logic       busy;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] rom_addr;
   logic       rom_en;
   logic [7:0] rom_data;
   logic [7:0] result;
   logic       result_valid;
   logic       result_ready;
   logic       done;

   logic [7:0] rom [256];
   int checks   = 0;
   int failures = 0;
   int cyc;

   always #5 clk = ~clk;

   assign rom_data = rom_en ? rom[rom_addr] : 8'h00;

   neuron_mac_sequencer #(
      .N_INPUTS (3),
      .ADDR_W   (8),
      .DATA_W   (8),
      .ACC_W    (20)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .base_addr    (base_addr),
      .busy         (busy),
      .in_data      (in_data),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .rom_addr     (rom_addr),
      .rom_en       (rom_en),
      .rom_data     (rom_data),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready),
      .done         (done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Starts an evaluation from the current (post-edge) time and waits for result_valid.
   task automatic run(input logic [7:0] b, input logic [7:0] x0, input logic [7:0] x1,
                      input logic [7:0] x2, input bit stall, input int exp_res, input int exp_lat);
      logic [7:0] xs [3];
      logic [7:0] a;
      int n;
      xs[0] = x0; xs[1] = x1; xs[2] = x2;
      cyc = 0;
      start = 1'b1;
      base_addr = b;
      step();
      start = 1'b0;
      chk("mac_busy", busy, 1);
      chk("mac_rom_en", rom_en, 1);
      chk("mac_in_ready", in_ready, 1);
      for (int i = 0; i < 3; i++) begin
         a = b + 8'(i);
         if (stall && i == 1) begin
            in_valid = 1'b0;
            for (int s = 0; s < 3; s++) begin
               step();
               chk("stall_addr_hold", rom_addr, a);
            end
         end
         chk("mac_addr", rom_addr, a);
         in_valid = 1'b1;
         in_data  = xs[i];
         step();
      end
      in_valid = 1'b0;
      a = b + 8'd3;
      chk("bias_addr", rom_addr, a);
      chk("bias_in_ready", in_ready, 0);
      chk("bias_rom_en", rom_en, 1);
      n = 0;
      while (!result_valid && n < 20) begin
         step();
         n++;
      end
      chk("latency", cyc, exp_lat);
      chk("result", result, exp_res);
      chk("out_rom_en", rom_en, 0);
      chk("out_done_low", done, 0);
   endtask

   // Holds result_ready low for 'hold' cycles (optionally pulsing start), then accepts.
   task automatic accept(input int hold, input bit poke_start);
      logic [7:0] r;
      r = result;
      for (int h = 0; h < hold; h++) begin
         if (poke_start && h == 3) start = 1'b1;
         step();
         start = 1'b0;
         chk("hold_valid", result_valid, 1);
         chk("hold_result", result, r);
         chk("hold_done", done, 0);
         chk("hold_busy", busy, 1);
      end
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("acc_valid_low", result_valid, 0);
      chk("acc_done", done, 1);
      chk("acc_busy", busy, 0);
      chk("acc_result_kept", result, r);
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      base_addr = 8'd0;
      in_data = 8'd0;
      in_valid = 1'b0;
      result_ready = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 8'd0;
      rom[0] = 8'd10; rom[1] = 8'd10; rom[2] = 8'd11; rom[3] = 8'd11;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_rom_en", rom_en, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_rom_addr", rom_addr, 0);
      rst_n = 1'b1;
      step();

      // 1*10 + 2*10 + 3*11 + 11 = 74
      run(8'd0, 8'd1, 8'd2, 8'd3, 1'b0, 74, 5);
      accept(0, 1'b0);
      step();
      chk("done_single_pulse", done, 0);

      run(8'd0, 8'd1, 8'd2, 8'd3, 1'b1, 74, 8);
      accept(0, 1'b0);

      // Back-to-back start on the done cycle; 3*127*127 saturates to 127.
      rom[0] = 8'd127; rom[1] = 8'd127; rom[2] = 8'd127; rom[3] = 8'd0;
      run(8'd0, 8'd127, 8'd127, 8'd127, 1'b0, 127, 5);
      accept(0, 1'b0);

      // -5*31 + 11 = -144 clamps to 0; start poked while waiting must be ignored.
      rom[0] = 8'd10; rom[1] = 8'd10; rom[2] = 8'd11; rom[3] = 8'd11;
      run(8'd0, 8'hFB, 8'hFB, 8'hFB, 1'b0, 0, 5);
      accept(10, 1'b1);
      step();
      chk("poke_ignored_busy", busy, 0);
      chk("poke_ignored_done", done, 0);
      step();
      chk("poke_ignored_busy2", busy, 0);

      // Address wrap: 254,255,0 weights and bias at 1 -> 1+2+3+4 = 10.
      rom[254] = 8'd1; rom[255] = 8'd2; rom[0] = 8'd3; rom[1] = 8'd4;
      run(8'd254, 8'd1, 8'd1, 8'd1, 1'b0, 10, 5);
      accept(0, 1'b0);

      // Abort during MAC after two inputs, then a clean evaluation.
      rom[0] = 8'd10; rom[1] = 8'd10; rom[2] = 8'd11; rom[3] = 8'd11;
      start = 1'b1;
      base_addr = 8'd0;
      step();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'd50;
      step();
      step();
      in_valid = 1'b0;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_in_ready", in_ready, 0);
      chk("abort_rom_en", rom_en, 0);
      chk("abort_valid", result_valid, 0);
      step();
      chk("abort_no_done", done, 0);
      run(8'd0, 8'd1, 8'd2, 8'd3, 1'b0, 74, 5);
      accept(0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
